// File: rtl/axi_perf_pkg.sv
// Shared definitions for the AXI perf traffic generators (axi_perf_rd, axi_perf_wr).
package axi_perf_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ISSUE_IDLE  = 2'd0,
    ISSUE_ADDR  = 2'd1,
    ISSUE_DRAIN = 2'd2
  } issue_state_e;

endpackage

// File: rtl/axi_perf_rd_check.sv
// Returned-data checker: rebuilds each beat's expected value from the burst/beat
// position and keeps a sticky error flag plus a saturating error count.
module axi_perf_rd_check
  import axi_perf_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          beat_valid,
  input  logic [DW-1:0] rdata,
  input  logic [1:0]    rresp,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] stride,
  input  logic [2:0]    size,
  input  logic [15:0]   r_idx,
  input  logic [7:0]    beat_idx,
  output logic          rd_err,
  output logic [15:0]   rd_err_cnt
);

  localparam int XW = (DW > AW) ? DW : AW;

  logic [AW+15:0] stride_prod;
  logic [AW-1:0]  burst_addr;
  logic [AW-1:0]  beat_off;
  logic [AW-1:0]  exp_addr;
  logic [XW-1:0]  exp_ext;
  logic [DW-1:0]  exp_data;
  logic           beat_bad;
  logic           rd_err_d, rd_err_q;
  logic [15:0]    err_cnt_d, err_cnt_q;

  always_comb begin
    stride_prod = (AW+16)'(r_idx) * (AW+16)'(stride);
    burst_addr  = base_addr + stride_prod[AW-1:0];
    // beat_idx << 7 needs at most 15 bits
    beat_off    = AW'({7'd0, beat_idx} << size);
    exp_addr    = burst_addr + beat_off;
    exp_ext     = XW'(exp_addr);
    exp_data    = exp_ext[DW-1:0];
    beat_bad    = beat_valid && ((rdata != exp_data) || (rresp != AXI_RESP_OKAY));
    rd_err_d    = rd_err_q;
    err_cnt_d   = err_cnt_q;
    if (clear) begin
      rd_err_d  = 1'b0;
      err_cnt_d = '0;
    end else if (beat_bad) begin
      rd_err_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rd_err_q  <= rd_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_err     = rd_err_q;
  assign rd_err_cnt = err_cnt_q;

endmodule

// File: rtl/axi_perf_rd.sv
// Read-side AXI traffic generator: issues burst_num INCR bursts, sinks all R beats.
// Define AXI_PERF_RD_CHECK_EN to compile in returned-data checking.
module axi_perf_rd
  import axi_perf_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH  = 20,
  parameter int AXI_DATA_WIDTH  = 16,
  parameter int AXI_ID_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]                burst_beats,
  input  logic [AXI_ADDR_WIDTH-1:0] burst_stride,
  input  logic [15:0]               burst_num,
  input  logic [2:0]                burst_arsize,
  output logic                      rd_err,
  output logic [15:0]               rd_err_cnt,
  output logic                      m_axi_arvalid,
  output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  input  logic                      m_axi_arready,
  input  logic                      m_axi_rvalid,
  input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  output logic                      m_axi_rready,
  output issue_state_e              dbg_state
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE_OUT = OW'(1);

  // Handshakes: a transfer happens on any clock edge where valid && ready.
  // rready simply mirrors busy; arvalid only rises when a slot is free.
  issue_state_e  state_d, state_q;
  logic          busy_d, busy_q, arvalid_d, arvalid_q;
  logic [AW-1:0] base_d, base_q, stride_d, stride_q, araddr_d, araddr_q;
  logic [7:0]    arlen_d, arlen_q, beat_idx_d, beat_idx_q;
  logic [2:0]    arsize_d, arsize_q;
  logic [15:0]   num_d, num_q, ar_idx_d, ar_idx_q, r_idx_d, r_idx_q;
  logic [OW-1:0] outst_d, outst_q;
  logic          start_acc, ar_hs, r_hs, rlast_hs, drained;

  assign start_acc = start && (state_q == ISSUE_IDLE);
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign r_hs      = m_axi_rvalid && busy_q;
  assign rlast_hs  = r_hs && m_axi_rlast;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    stride_d   = stride_q;
    num_d      = num_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    ar_idx_d   = ar_idx_q;
    r_idx_d    = r_idx_q;
    beat_idx_d = beat_idx_q;
    outst_d    = outst_q;
    if (ar_hs) begin
      ar_idx_d = ar_idx_q + 16'd1;
      araddr_d = araddr_q + stride_q;
    end
    if (r_hs) begin
      if (m_axi_rlast) begin
        beat_idx_d = '0;
        r_idx_d    = r_idx_q + 16'd1;
      end else begin
        beat_idx_d = beat_idx_q + 8'd1;
      end
    end
    if (ar_hs && !rlast_hs)      outst_d = outst_q + ONE_OUT;
    else if (!ar_hs && rlast_hs) outst_d = outst_q - ONE_OUT;
    drained = (outst_d == '0) && (r_idx_d == num_q);
    case (state_q)
      ISSUE_IDLE: begin
        if (start_acc) begin
          state_d    = ISSUE_ADDR;
          base_d     = base_addr;
          stride_d   = burst_stride;
          num_d      = burst_num;
          araddr_d   = base_addr;
          arlen_d    = (burst_beats == 8'd0) ? 8'd0 : burst_beats - 8'd1;
          arsize_d   = burst_arsize;
          ar_idx_d   = '0;
          r_idx_d    = '0;
          beat_idx_d = '0;
          outst_d    = '0;
        end
      end
      // An empty run (burst_num == 0) is already drained and drops straight back.
      ISSUE_ADDR:  if (ar_idx_d == num_q) state_d = drained ? ISSUE_IDLE : ISSUE_DRAIN;
      ISSUE_DRAIN: if (drained) state_d = ISSUE_IDLE;
      default:     state_d = ISSUE_IDLE;
    endcase
    arvalid_d = (state_d == ISSUE_ADDR) && (ar_idx_d < num_d) && (outst_d < MAX_OUT);
    busy_d    = (state_d != ISSUE_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ISSUE_IDLE;
      busy_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      num_q      <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      ar_idx_q   <= '0;
      r_idx_q    <= '0;
      beat_idx_q <= '0;
      outst_q    <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      arvalid_q  <= arvalid_d;
      base_q     <= base_d;
      stride_q   <= stride_d;
      num_q      <= num_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      ar_idx_q   <= ar_idx_d;
      r_idx_q    <= r_idx_d;
      beat_idx_q <= beat_idx_d;
      outst_q    <= outst_d;
    end
  end

  assign busy          = busy_q;
  assign dbg_state     = state_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arid    = '0;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_rready  = busy_q;

  // Single-ID, in-order responses: rid carries no information.
  logic unused_rid;
  assign unused_rid = ^m_axi_rid;

`ifdef AXI_PERF_RD_CHECK_EN
  axi_perf_rd_check #(
    .AW(AW),
    .DW(AXI_DATA_WIDTH)
  ) u_check (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_acc),
    .beat_valid (r_hs),
    .rdata      (m_axi_rdata),
    .rresp      (m_axi_rresp),
    .base_addr  (base_q),
    .stride     (stride_q),
    .size       (arsize_q),
    .r_idx      (r_idx_q),
    .beat_idx   (beat_idx_q),
    .rd_err     (rd_err),
    .rd_err_cnt (rd_err_cnt)
  );
`else
  logic unused_rdata;
  assign unused_rdata = ^{m_axi_rdata, m_axi_rresp, base_q};
  assign rd_err       = 1'b0;
  assign rd_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_axi_perf_rd.sv
// Bench for axi_perf_rd: in-order memory-model slave plus an AR address scoreboard.
`timescale 1ns/1ps
module tb_axi_perf_rd;
  import axi_perf_pkg::*;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int MAXO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start;
  logic          busy;
  logic [AW-1:0] base_addr;
  logic [7:0]    burst_beats;
  logic [AW-1:0] burst_stride;
  logic [15:0]   burst_num;
  logic [2:0]    burst_arsize;
  logic          rd_err;
  logic [15:0]   rd_err_cnt;
  logic          m_axi_arvalid;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arready = 1'b0;
  logic          m_axi_rvalid  = 1'b0;
  logic [IW-1:0] m_axi_rid     = '0;
  logic [DW-1:0] m_axi_rdata   = '0;
  logic [1:0]    m_axi_rresp   = 2'b00;
  logic          m_axi_rlast   = 1'b0;
  logic          m_axi_rready;
  issue_state_e  dbg_state;

  axi_perf_rd #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .base_addr     (base_addr),
    .burst_beats   (burst_beats),
    .burst_stride  (burst_stride),
    .burst_num     (burst_num),
    .burst_arsize  (burst_arsize),
    .rd_err        (rd_err),
    .rd_err_cnt    (rd_err_cnt),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arready (m_axi_arready),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rready  (m_axi_rready),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected AR addresses, pushed at run setup
  logic [AW-1:0] exp_q[$];
  logic [7:0]    exp_len;
  logic [2:0]    exp_size;

  // slave knobs and run statistics
  int rdelay = 2;
  bit ar_rand = 1'b0;
  int corrupt_burst = -1, corrupt_beat = -1, err_burst = -1, err_beat = -1;
  int run_num = 0;
  int cyc = 0, ar_cnt = 0, beat_cnt = 0, r_burst = 0, beat = 0;
  int model_out = 0, max_out = 0, ar_pre_rlast = 0, sim_cnt = 0;
  bit seen_rlast = 0, fin_pending = 0, ar_wait = 0, arvalid_seen = 0;
  logic [AW-1:0] wait_addr;
  int            rq_time[$];
  logic [AW-1:0] rq_addr[$];
  logic [7:0]    rq_len[$];
  logic [2:0]    rq_size[$];

  // in-order memory-model slave, driven and sampled on the falling edge
  always @(negedge clk) begin
    logic          ar_hs, r_hs, r_last;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    cyc++;
    if (!rst_n) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      rq_time.delete(); rq_addr.delete(); rq_len.delete(); rq_size.delete();
      beat = 0; model_out = 0; ar_wait = 1'b0; fin_pending = 1'b0;
    end else begin
      if (fin_pending) chk("busy_fall", busy, 1'b0);
      fin_pending = 1'b0;
      if (ar_wait) begin
        chk("ar_hold_valid", m_axi_arvalid, 1'b1);
        chk("ar_hold_addr", m_axi_araddr, wait_addr);
      end
      if (busy && ar_cnt < run_num && model_out < MAXO) chk("ar_no_stall", m_axi_arvalid, 1'b1);
      if (m_axi_arvalid) begin
        arvalid_seen = 1'b1;
        chk("ar_limit", model_out < MAXO, 1'b1);
      end
      m_axi_arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_hs     = m_axi_arvalid && m_axi_arready;
      ar_wait   = m_axi_arvalid && !m_axi_arready;
      wait_addr = m_axi_araddr;
      if (rq_time.size() > 0 && cyc >= rq_time[0]) begin
        a = rq_addr[0] + AW'(beat) * (AW'(1) << rq_size[0]);
        d = DW'(a);
        if (r_burst == corrupt_burst && beat == corrupt_beat) d = d ^ DW'(4);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = d;
        m_axi_rresp  = (r_burst == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (beat == int'(rq_len[0]));
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
      end
      r_hs   = m_axi_rvalid && m_axi_rready;
      r_last = r_hs && m_axi_rlast;
      if (ar_hs) begin
        ar_cnt++;
        if (!seen_rlast) ar_pre_rlast++;
        if (exp_q.size() == 0) begin
          chk("ar_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          a = exp_q.pop_front();
          chk("araddr", m_axi_araddr, a);
          chk("arlen", m_axi_arlen, exp_len);
          chk("arsize", m_axi_arsize, exp_size);
          chk("arburst", m_axi_arburst, 2'b01);
          chk("arid", m_axi_arid, '0);
          rq_time.push_back(cyc + rdelay);
          rq_addr.push_back(a);
          rq_len.push_back(exp_len);
          rq_size.push_back(exp_size);
        end
      end
      if (r_hs) begin
        beat_cnt++;
        beat++;
        if (m_axi_rlast) begin
          seen_rlast = 1'b1;
          beat = 0;
          r_burst++;
          if (ar_hs && model_out == 3) sim_cnt++;
          void'(rq_time.pop_front()); void'(rq_addr.pop_front());
          void'(rq_len.pop_front());  void'(rq_size.pop_front());
          fin_pending = (r_burst == run_num);
        end
      end
      if (ar_hs && !r_last) model_out++;
      else if (!ar_hs && r_last) model_out--;
      if (model_out > max_out) max_out = model_out;
    end
  end

  // driver tasks
  task automatic setup(input logic [AW-1:0] base, input logic [7:0] beats,
                       input logic [AW-1:0] stride, input logic [15:0] num, input logic [2:0] size);
    base_addr    = base;
    burst_beats  = beats;
    burst_stride = stride;
    burst_num    = num;
    burst_arsize = size;
    exp_len      = (beats == 8'd0) ? 8'd0 : beats - 8'd1;
    exp_size     = size;
    exp_q.delete();
    for (int i = 0; i < int'(num); i++) exp_q.push_back(base + AW'(i) * stride);
    run_num = int'(num);
    ar_cnt = 0; beat_cnt = 0; r_burst = 0; max_out = 0;
    ar_pre_rlast = 0; sim_cnt = 0; seen_rlast = 1'b0; arvalid_seen = 1'b0;
  endtask

  task automatic kick(input string tag);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config: a run must use only what was latched at start
    base_addr    = AW'($urandom);
    burst_beats  = 8'($urandom);
    burst_stride = AW'($urandom);
    burst_num    = 16'($urandom);
    burst_arsize = 3'($urandom);
    chk({tag, "_busy_rise"}, busy, 1'b1);
    chk({tag, "_arvalid_first"}, m_axi_arvalid, run_num != 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, busy, 1'b0);
    if (busy) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic finish_checks(input string tag, input int beats_per,
                               input logic exp_err, input logic [15:0] exp_cnt);
    chk({tag, "_ar_cnt"}, ar_cnt, run_num);
    chk({tag, "_beat_cnt"}, beat_cnt, run_num * beats_per);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_rd_err"}, rd_err, exp_err);
    chk({tag, "_rd_err_cnt"}, rd_err_cnt, exp_cnt);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    chk({tag, "_rready"}, m_axi_rready, 1'b0);
    chk({tag, "_rd_err"}, rd_err, 1'b0);
    chk({tag, "_rd_err_cnt"}, rd_err_cnt, 16'd0);
    chk({tag, "_araddr"}, m_axi_araddr, '0);
    chk({tag, "_arlen"}, m_axi_arlen, 8'd0);
    chk({tag, "_arsize"}, m_axi_arsize, 3'd0);
    chk({tag, "_arburst"}, m_axi_arburst, 2'b01);
    chk({tag, "_arid"}, m_axi_arid, '0);
    chk({tag, "_state"}, dbg_state, ISSUE_IDLE);
  endtask

  initial begin
    logic       chk_err;
    logic [15:0] chk_cnt;
`ifdef AXI_PERF_RD_CHECK_EN
    chk_err = 1'b1; chk_cnt = 16'd2;
`else
    chk_err = 1'b0; chk_cnt = 16'd0;
`endif
    rst_n = 1'b0; start = 1'b0;
    base_addr = '0; burst_beats = '0; burst_stride = '0; burst_num = '0; burst_arsize = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single burst
    rdelay = 2;
    setup(20'h00100, 8'd4, 20'h0, 16'd1, 3'd1);
    kick("single");
    wait_done("single");
    finish_checks("single", 4, 1'b0, 16'd0);

    // outstanding limit, with a start pulse while busy
    rdelay = 20;
    setup(20'h01000, 8'd2, 20'h40, 16'd8, 3'd1);
    kick("outst");
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 20'hAAAA0; burst_num = 16'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("outst");
    chk("outst_ar_before_rlast", ar_pre_rlast, 4);
    chk("outst_max", max_out, 4);
    finish_checks("outst", 2, 1'b0, 16'd0);

    // AR and rlast handshakes coinciding at outstanding == 3
    rdelay = 3;
    setup(20'h02000, 8'd1, 20'h10, 16'd12, 3'd2);
    kick("sim");
    wait_done("sim");
    chk("sim_events_seen", sim_cnt > 0, 1'b1);
    chk("sim_max", max_out, 3);
    finish_checks("sim", 1, 1'b0, 16'd0);

    // address wrap with random arready
    rdelay = 1; ar_rand = 1'b1;
    setup(20'hFFF00, 8'd2, 20'h80, 16'd4, 3'd1);
    kick("wrap");
    wait_done("wrap");
    finish_checks("wrap", 2, 1'b0, 16'd0);
    ar_rand = 1'b0;

    // burst_beats == 0 acts as single-beat bursts
    setup(20'h00300, 8'd0, 20'h20, 16'd3, 3'd0);
    kick("beats0");
    wait_done("beats0");
    finish_checks("beats0", 1, 1'b0, 16'd0);

    // data corruption on burst 1 beat 2, SLVERR on burst 2 beat 0
    rdelay = 2;
    corrupt_burst = 1; corrupt_beat = 2; err_burst = 2; err_beat = 0;
    setup(20'h04000, 8'd4, 20'h100, 16'd3, 3'd1);
    kick("errs");
    wait_done("errs");
    finish_checks("errs", 4, chk_err, chk_cnt);
    corrupt_burst = -1; corrupt_beat = -1; err_burst = -1; err_beat = -1;

    // clean run clears the error state
    setup(20'h05000, 8'd4, 20'h100, 16'd2, 3'd2);
    kick("clean");
    chk("clean_err_cleared", rd_err, 1'b0);
    chk("clean_cnt_cleared", rd_err_cnt, 16'd0);
    wait_done("clean");
    finish_checks("clean", 4, 1'b0, 16'd0);

    // burst_num == 0: one busy cycle, no AR
    setup(20'h00600, 8'd4, 20'h10, 16'd0, 3'd1);
    kick("num0");
    @(posedge clk); #1;
    chk("num0_busy_fall", busy, 1'b0);
    chk("num0_no_arvalid", arvalid_seen, 1'b0);
    chk("num0_ar_cnt", ar_cnt, 0);

    // reset mid-run
    rdelay = 5;
    setup(20'h07000, 8'd4, 20'h40, 16'd8, 3'd1);
    kick("midrst");
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle("midrst");
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;

    // recovery after reset
    setup(20'h08000, 8'd2, 20'h10, 16'd2, 3'd0);
    kick("recover");
    wait_done("recover");
    finish_checks("recover", 2, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_perf_rd.md
# axi_perf_rd

Read-side traffic generator for the AXI perf harness: on `start` it issues `burst_num` INCR read bursts at `base_addr + i*burst_stride`, keeping up to `MAX_OUTSTANDING` bursts in flight, and sinks all R beats at full rate. It is the read counterpart of `axi_perf_wr`. One instance per manager port feeds the read channels of `svc_axi_arbiter`, replacing the null read stubs. With checking compiled in, it also verifies returned data against the address pattern.

## Interface
- `AXI_ADDR_WIDTH`, 20: address width (AW).
- `AXI_DATA_WIDTH`, 16: data width (DW).
- `AXI_ID_WIDTH`, 4: ID width.
- `MAX_OUTSTANDING`, 4: maximum AR-accepted bursts whose `rlast` has not yet been received; must be ≥1.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begin a run; ignored while `busy`.
- `busy`  out  1: run in progress.
- `base_addr`  in  AW: first burst address.
- `burst_beats`  in  8: beats per burst.
- `burst_stride`  in  AW: address increment between bursts.
- `burst_num`  in  16: number of bursts.
- `burst_arsize`  in  3: `arsize` for all bursts.
- `rd_err`  out  1: sticky check failure, cleared on `start`.
- `rd_err_cnt`  out  16: count of failing beats, saturating, cleared on `start`.
- AR channel outputs: `m_axi_arvalid` 1, `m_axi_arid` ID, `m_axi_araddr` AW, `m_axi_arlen` 8, `m_axi_arsize` 3, `m_axi_arburst` 2.
- AR channel input: `m_axi_arready` 1.
- R channel inputs: `m_axi_rvalid` 1, `m_axi_rid` ID, `m_axi_rdata` DW, `m_axi_rresp` 2, `m_axi_rlast` 1.
- R channel output: `m_axi_rready` 1.

## Operation
- **Start:** `start` with `!busy` latches all config inputs. Later config changes have no effect until the next run. The same cycle clears the AR and R burst counters, the outstanding count, `rd_err` and `rd_err_cnt`.
- **Issue FSM** (states IDLE → ADDR → DRAIN → IDLE):
  - ADDR: drive `arvalid` while `ar_idx < burst_num` and `outstanding < MAX_OUTSTANDING`.
  - Leave ADDR for DRAIN when `ar_idx == burst_num`.
  - Leave DRAIN for IDLE when `outstanding == 0` and `r_idx == burst_num`.
- **AR fields:**
  - `araddr = base_addr + ar_idx*burst_stride`, truncated mod 2^AW. Wrap-around is legal.
  - `arlen = burst_beats - 1`. `burst_beats == 0` is treated as 1 (`arlen = 0`).
  - `arburst = 2'b01` (INCR); `arsize = burst_arsize`; `arid = 0`.
- **AR handshake:** `arvalid && arready` increments `ar_idx` and `outstanding`. Address and length stay stable while `arvalid && !arready`.
- **R handshake:** `rready = busy`. Each `rvalid && rready` increments `beat_idx`. A beat with `rlast` resets `beat_idx`, increments `r_idx` and decrements `outstanding`.
- **Simultaneous AR handshake and `rlast` handshake:** `outstanding` is unchanged.
- **Ignored fields:** `rid` is ignored; responses are in order with a single ID.
- **`burst_num == 0`:** `busy` is high for exactly one cycle and no AR is issued.
- **Reset mid-run:** returns to IDLE and drops `arvalid`, `rready` and `busy` immediately. In-flight R beats are not the block's concern.

## Timing
- Reset values: `busy`, `arvalid`, `rready`, `rd_err` are 0; `rd_err_cnt` is 0; `araddr`, `arlen`, `arsize` are 0; `arburst` is 2'b01; `arid` is 0.
- `start` at cycle N gives `busy = 1` and the first `arvalid = 1` at N+1.
- Back-to-back AR: a new `arvalid` burst is presented the cycle after a handshake with no bubble, unless the outstanding limit is reached.
- When `outstanding == MAX_OUTSTANDING`, `arvalid` drops the cycle after the handshake that filled it. It may reassert the cycle after the `rlast` handshake that frees a slot.
- `busy` falls the cycle after the final `rlast` handshake.
- `start` while `busy`: ignored, with no effect on the counters.

## Configuration
- `AXI_PERF_RD_CHECK_EN` defined:
  - Each accepted beat is compared with its expected value, which is `burst_addr + beat_idx*(1 << arsize)` truncated or zero-extended to DW.
  - The R side recomputes `burst_addr` from `r_idx`.
  - A mismatch, or `rresp != 2'b00`, sets `rd_err` and increments `rd_err_cnt`.
  - Result outputs are registered: they update one cycle after the beat.
- `AXI_PERF_RD_CHECK_EN` undefined: no comparator logic; `rd_err` and `rd_err_cnt` are tied to 0. All other behaviour is identical.

## Structure
- Shared package `axi_perf_pkg` holds:
  - the `AXI_BURST_INCR` and `AXI_RESP_OKAY` constants;
  - the issue state enum, shared with `axi_perf_wr`.
- Sub-module `axi_perf_rd_check` holds the expected-value generator and error counter. It is instantiated only under the macro.

## Test plan
- **Single burst:** base 0x100, beats 4, num 1, size 1, memory model with `arready` always high. Expect one AR with `araddr` 0x100 and `arlen` 3, 4 beats accepted, `busy` high for the run then low, `rd_err` = 0.
- **Outstanding limit:** num 8, MAX_OUTSTANDING 4, slave delays R by 20 cycles. Expect exactly 4 ARs accepted before the first `rlast`, and `outstanding` never above 4.
- **Simultaneous events:** an AR handshake and an `rlast` handshake in the same cycle, with `outstanding` at 3. Expect `outstanding` to stay at 3 and the next AR to issue without stall.
- **Address wrap:** AW 20, base 0xFFF00, stride 0x80, num 4. Expect `araddr` sequence 0xFFF00, 0xFFF80, 0x00000, 0x00080.
- **Check (macro on):** the slave corrupts beat 2 of burst 1 and returns SLVERR on one other beat. Expect `rd_err` = 1 and `rd_err_cnt` = 2. A following clean run clears both to 0.
- **Edge cases:** `burst_num == 0` gives `busy` for one cycle and no `arvalid`. Reset asserted mid-run gives all outputs at reset values the next cycle.
